rolha_supply_ctrl: RTL and testbench

Parametrised cork-supply and sealing controller for the bottling line. It combines four functions: a saturating warehouse stock counter, a bounded dispenser buffer with manual or automatic batch refill, a low-level flag (a generalised replacement for the fixed "equals 5" detector), and the sealing state machine with alarm. It sits between the operator stock inputs and the capping station, and drives the dispenser and sealer actuators.

---
 rtl/rolha_supply_ctrl.sv | 101 ++++++++++
 tb/tb_rolha_supply_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rolha_supply_ctrl.sv
// Cork supply and sealing controller: saturating warehouse stock, bounded dispenser
// with manual or automatic batch refill, low-level flag and the sealing FSM with alarm.
module rolha_supply_ctrl #(
  parameter int W           = 8,
  parameter int DISP_MAX    = 10,
  parameter int REFILL_LOW  = 5,
  parameter int BATCH       = 5,
  parameter bit AUTO_REFILL = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_stock,
  input  logic [W-1:0] qntsrolhas,
  input  logic         switch_add_rolha,
  input  logic         gar,
  input  logic         pos,
  output logic [W-1:0] estoque,
  output logic [W-1:0] rolha_disponivel,
  output logic         disp,
  output logic         add_rolha,
  output logic         rolha_low,
  output logic         ve,
  output logic         done,
  output logic         alarme
);

  typedef enum logic [2:0] {IDLE, SEAL, DONE, RELEASE, ALARM} state_e;

  localparam logic [W-1:0] DISP_MAX_W   = W'(DISP_MAX);
  localparam logic [W-1:0] REFILL_LOW_W = W'(REFILL_LOW);
  localparam logic [W-1:0] BATCH_W      = W'(BATCH);

  state_e       state_q, state_d;
  logic [W-1:0] stock_q, stock_d;
  logic [W-1:0] level_q, level_d;
  logic         disp_q;

  logic         req, xfer, level_nz;
  logic [W-1:0] room, n;
  logic [W:0]   stock_sum;

  assign rolha_low = (level_q <= REFILL_LOW_W);
  assign add_rolha = (stock_q == '0) && rolha_low;
  assign level_nz  = (level_q != '0);
  assign req       = switch_add_rolha || (AUTO_REFILL && rolha_low);
  assign xfer      = req && (stock_q != '0) && (level_q < DISP_MAX_W);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    room = DISP_MAX_W - level_q;
    n    = BATCH_W;
    if (stock_q < n) n = stock_q;
    if (room < n)    n = room;

    // One extra bit holds the load overflow so saturation is applied after both terms.
    stock_sum = {1'b0, stock_q}
              - (xfer       ? {1'b0, n}          : '0)
              + (load_stock ? {1'b0, qntsrolhas} : '0);
    stock_d   = stock_sum[W] ? '1 : stock_sum[W-1:0];

    level_d   = level_q + (xfer ? n : '0) - W'(state_q == SEAL);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gar && pos) state_d = level_nz ? SEAL : ALARM;
      SEAL:    state_d = DONE;
      DONE:    state_d = RELEASE;
      RELEASE: if (!gar) state_d = IDLE;
      ALARM: begin
        if (gar && pos && level_nz) state_d = SEAL;
        else if (!gar)              state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stock_q <= '0;
      level_q <= '0;
      disp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stock_q <= stock_d;
      level_q <= level_d;
      disp_q  <= xfer;
    end
  end

  assign estoque          = stock_q;
  assign rolha_disponivel = level_q;
  assign disp             = disp_q;
  assign ve               = (state_q == SEAL);
  assign done             = (state_q == DONE);
  assign alarme           = (state_q == ALARM);

endmodule

// File: tb/tb_rolha_supply_ctrl.sv
// Scoreboard bench: stimulus queues expected outputs per cycle for an auto-refill and a
// manual-refill instance; a negedge monitor pops and compares them.
module tb_rolha_supply_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_stock = 1'b0;
  logic [7:0] qntsrolhas = '0;
  logic       switch_add_rolha = 1'b0;
  logic       gar = 1'b0;
  logic       pos = 1'b0;

  logic [7:0] est_a, lvl_a, est_m, lvl_m;
  logic       disp_a, add_a, low_a, ve_a, done_a, al_a;
  logic       disp_m, add_m, low_m, ve_m, done_m, al_m;

  always #5 clk = ~clk;

  rolha_supply_ctrl #(.AUTO_REFILL(1'b1)) u_auto (
    .clk(clk), .reset(reset), .load_stock(load_stock), .qntsrolhas(qntsrolhas),
    .switch_add_rolha(switch_add_rolha), .gar(gar), .pos(pos),
    .estoque(est_a), .rolha_disponivel(lvl_a), .disp(disp_a), .add_rolha(add_a),
    .rolha_low(low_a), .ve(ve_a), .done(done_a), .alarme(al_a));

  rolha_supply_ctrl #(.AUTO_REFILL(1'b0)) u_man (
    .clk(clk), .reset(reset), .load_stock(load_stock), .qntsrolhas(qntsrolhas),
    .switch_add_rolha(switch_add_rolha), .gar(gar), .pos(pos),
    .estoque(est_m), .rolha_disponivel(lvl_m), .disp(disp_m), .add_rolha(add_m),
    .rolha_low(low_m), .ve(ve_m), .done(done_m), .alarme(al_m));

  typedef struct {
    int          cyc;
    bit          sel_man;
    string       name;
    logic [21:0] vec;  // {estoque, level, disp, add_rolha, rolha_low, ve, done, alarme}
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [21:0] act;
      e = q.pop_front();
      act = e.sel_man ? {est_m, lvl_m, disp_m, add_m, low_m, ve_m, done_m, al_m}
                      : {est_a, lvl_a, disp_a, add_a, low_a, ve_a, done_a, al_a};
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: expectation for cycle %0d reached monitor at cycle %0d", e.name, e.cyc, cyc);
      end else if (act !== e.vec) begin
        bad++;
        $display("FAIL %s: got est=%0d lvl=%0d disp/add/low/ve/done/al=%b, want est=%0d lvl=%0d disp/add/low/ve/done/al=%b",
                 e.name, act[21:14], act[13:6], act[5:0], e.vec[21:14], e.vec[13:6], e.vec[5:0]);
      end
    end
  end

  task automatic drive(input logic rst, input logic ld, input logic [7:0] qty,
                       input logic sw, input logic g, input logic p);
    reset = rst; load_stock = ld; qntsrolhas = qty; switch_add_rolha = sw; gar = g; pos = p;
  endtask

  // Queue the outputs expected after the coming edge, then advance one cycle.
  task automatic step(input bit sel_man, input string nm, input logic [7:0] est,
                      input logic [7:0] lvl, input logic dsp, input logic ve_e,
                      input logic done_e, input logic al_e);
    exp_t e;
    logic low_e, add_e;
    low_e   = (lvl <= 8'd5);
    add_e   = (est == 8'd0) && low_e;
    e.cyc     = cyc + 1;
    e.sel_man = sel_man;
    e.name    = nm;
    e.vec     = {est, lvl, dsp, add_e, low_e, ve_e, done_e, al_e};
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Power-up load and two automatic batch transfers, then saturation.
    drive(1, 0, 0, 0, 0, 0);     step(0, "reset_state",   0,   0, 0, 0, 0, 0);
    drive(0, 1, 20, 0, 0, 0);    step(0, "load20",        20,  0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);     step(0, "xfer1",         15,  5, 1, 0, 0, 0);
                                 step(0, "xfer2",         10, 10, 1, 0, 0, 0);
                                 step(0, "full_idle",     10, 10, 0, 0, 0, 0);
    drive(0, 1, 250, 0, 0, 0);   step(0, "sat_load250",  255, 10, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);     step(0, "sat_load1",    255, 10, 0, 0, 0, 0);

    // Empty dispenser with a bottle in position: alarm, restock, then seal.
    drive(1, 0, 0, 0, 0, 0);     step(0, "rst2",           0,  0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1);     step(0, "alarm_enter",    0,  0, 0, 0, 0, 1);
    drive(0, 1, 3, 0, 1, 1);     step(0, "alarm_load3",    3,  0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 1);     step(0, "alarm_xfer3",    0,  3, 1, 0, 0, 1);
                                 step(0, "alarm_to_seal",  0,  3, 0, 1, 0, 0);
                                 step(0, "alarm_done",     0,  2, 0, 0, 1, 0);
                                 step(0, "alarm_release",  0,  2, 0, 0, 0, 0);
                                 step(0, "release_hold",   0,  2, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);     step(0, "back_idle",      0,  2, 0, 0, 0, 0);

    // Seal from level 6 drops level to 5, triggering a refill while the bottle stays.
    drive(1, 0, 0, 0, 0, 0);     step(0, "rst3",           0,  0, 0, 0, 0, 0);
    drive(0, 1, 6, 0, 0, 0);     step(0, "l6_load6",       6,  0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);     step(0, "l6_xfer5",       1,  5, 1, 0, 0, 0);
                                 step(0, "l6_xfer1",       0,  6, 1, 0, 0, 0);
    drive(0, 1, 10, 0, 0, 0);    step(0, "l6_load10",     10,  6, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1);     step(0, "l6_seal",       10,  6, 0, 1, 0, 0);
                                 step(0, "l6_done",       10,  5, 0, 0, 1, 0);
                                 step(0, "l6_refill",      5, 10, 1, 0, 0, 0);
                                 step(0, "l6_hold1",       5, 10, 0, 0, 0, 0);
                                 step(0, "l6_hold2",       5, 10, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);     step(0, "l6_idle",        5, 10, 0, 0, 0, 0);

    // Manual-refill instance: no transfer until the switch is held.
    drive(1, 0, 0, 0, 0, 0);     step(1, "m_rst",          0,  0, 0, 0, 0, 0);
    drive(0, 1, 8, 0, 0, 0);     step(1, "m_load8",        8,  0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);     step(1, "m_no_switch",    8,  0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);     step(1, "m_xfer5",        3,  5, 1, 0, 0, 0);
                                 step(1, "m_xfer3",        0,  8, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);     step(1, "m_settle",       0,  8, 0, 0, 0, 0);

    // Reset while sealing with level 4 and stock 7.
    drive(1, 0, 0, 0, 0, 0);     step(0, "rst4",           0,  0, 0, 0, 0, 0);
    drive(0, 1, 4, 0, 0, 0);     step(0, "r_load4",        4,  0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);     step(0, "r_xfer4",        0,  4, 1, 0, 0, 0);
    drive(0, 1, 7, 0, 1, 1);     step(0, "r_seal",         7,  4, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 1);     step(0, "r_reset_seal",   0,  0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);     step(0, "r_after",        0,  0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: %0d expectations unchecked, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
